// File: rtl/ascon_stream_if.sv
// rtl/ascon_stream_if.sv - serial pin front-end for a parallel Ascon AEAD core
//
// Shifts key/nonce/AD/data/expected-tag in MSB-first, LANES bits per clock,
// launches the core, captures its data and tag, and shifts them back out.
// On decrypt the returned tag is compared on chip; with PT_GATE set, a
// failing compare returns an all-zero plaintext.
//
// Ports:
//   clk, rstb                  clock, asynchronous active-low reset
//   load_en, *_si              input beats (one per stream per clock)
//   decrypt, start             mode, run request (rising edge of start)
//   unload_en, data_so, tag_so output beats (current MSBs of the out regs)
//   ready, busy, auth_ok       status
//   core_*                     parallel operands, start/mode, results, done

module ascon_stream_if #(
    parameter int KEY_W   = 128,
    parameter int NONCE_W = 128,
    parameter int AD_W    = 40,
    parameter int DATA_W  = 104,
    parameter int TAG_W   = 128,
    parameter int LANES   = 1,
    parameter bit PT_GATE = 1'b1
) (
    input  logic              clk,
    input  logic              rstb,
    input  logic              load_en,
    input  logic [LANES-1:0]  key_si,
    input  logic [LANES-1:0]  nonce_si,
    input  logic [LANES-1:0]  ad_si,
    input  logic [LANES-1:0]  data_si,
    input  logic [LANES-1:0]  tag_si,
    input  logic              decrypt,
    input  logic              start,
    input  logic              unload_en,
    output logic [LANES-1:0]  data_so,
    output logic [LANES-1:0]  tag_so,
    output logic              ready,
    output logic              busy,
    output logic              auth_ok,
    output logic [KEY_W-1:0]  core_key,
    output logic [NONCE_W-1:0] core_nonce,
    output logic [AD_W-1:0]   core_ad,
    output logic [DATA_W-1:0] core_din,
    output logic              core_start,
    output logic              core_decrypt,
    input  logic [DATA_W-1:0] core_dout,
    input  logic [TAG_W-1:0]  core_tag,
    input  logic              core_done
);

    generate
        if ((LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) ||
            (KEY_W % LANES) != 0 || (NONCE_W % LANES) != 0 || (AD_W % LANES) != 0 ||
            (DATA_W % LANES) != 0 || (TAG_W % LANES) != 0) begin : g_bad_width
            $error("ascon_stream_if: LANES must be 1/2/4/8 and divide every stream width");
        end
    endgenerate

    localparam int CW = 16;
    localparam logic [CW-1:0] KEY_B   = CW'(KEY_W / LANES);
    localparam logic [CW-1:0] NONCE_B = CW'(NONCE_W / LANES);
    localparam logic [CW-1:0] AD_B    = CW'(AD_W / LANES);
    localparam logic [CW-1:0] DATA_B  = CW'(DATA_W / LANES);
    localparam logic [CW-1:0] TAG_B   = CW'(TAG_W / LANES);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_BUSY, S_DONE} state_t;
    state_t state;

    logic [KEY_W-1:0]   key_sr;
    logic [NONCE_W-1:0] nonce_sr;
    logic [AD_W-1:0]    ad_sr;
    logic [DATA_W-1:0]  din_sr;
    logic [TAG_W-1:0]   exp_tag;
    logic [CW-1:0]      key_cnt, nonce_cnt, ad_cnt, din_cnt, tag_cnt;
    logic [DATA_W-1:0]  dout_sr;
    logic [TAG_W-1:0]   tout_sr;
    logic               start_q;

    logic key_full, nonce_full, ad_full, din_full, tag_full, all_full;
    logic start_edge, load_first, load_more, tag_match;

    assign key_full   = (key_cnt == KEY_B);
    assign nonce_full = (nonce_cnt == NONCE_B);
    assign ad_full    = (ad_cnt == AD_B);
    assign din_full   = (din_cnt == DATA_B);
    assign tag_full   = (tag_cnt == TAG_B);
    assign all_full   = key_full & nonce_full & ad_full & din_full & tag_full;

    assign start_edge = start & ~start_q;
    // A load_en in IDLE or DONE opens a new run: its beat is the first one kept.
    assign load_first = load_en && (state == S_IDLE || state == S_DONE);
    assign load_more  = load_en && (state == S_LOAD);
    assign tag_match  = (core_tag == exp_tag);

    assign core_key   = key_sr;
    assign core_nonce = nonce_sr;
    assign core_ad    = ad_sr;
    assign core_din   = din_sr;
    assign data_so    = dout_sr[DATA_W-1 -: LANES];
    assign tag_so     = tout_sr[TAG_W-1 -: LANES];

    // Input shift registers; a full stream ignores further beats.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            key_sr    <= '0;
            nonce_sr  <= '0;
            ad_sr     <= '0;
            din_sr    <= '0;
            exp_tag   <= '0;
            key_cnt   <= '0;
            nonce_cnt <= '0;
            ad_cnt    <= '0;
            din_cnt   <= '0;
            tag_cnt   <= '0;
        end else if (load_first) begin
            key_sr    <= KEY_W'(key_si);
            nonce_sr  <= NONCE_W'(nonce_si);
            ad_sr     <= AD_W'(ad_si);
            din_sr    <= DATA_W'(data_si);
            exp_tag   <= TAG_W'(tag_si);
            key_cnt   <= CW'(1);
            nonce_cnt <= CW'(1);
            ad_cnt    <= CW'(1);
            din_cnt   <= CW'(1);
            tag_cnt   <= CW'(1);
        end else if (load_more) begin
            if (!key_full) begin
                key_sr  <= KEY_W'({key_sr, key_si});
                key_cnt <= key_cnt + CW'(1);
            end
            if (!nonce_full) begin
                nonce_sr  <= NONCE_W'({nonce_sr, nonce_si});
                nonce_cnt <= nonce_cnt + CW'(1);
            end
            if (!ad_full) begin
                ad_sr  <= AD_W'({ad_sr, ad_si});
                ad_cnt <= ad_cnt + CW'(1);
            end
            if (!din_full) begin
                din_sr  <= DATA_W'({din_sr, data_si});
                din_cnt <= din_cnt + CW'(1);
            end
            if (!tag_full) begin
                exp_tag <= TAG_W'({exp_tag, tag_si});
                tag_cnt <= tag_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state        <= S_IDLE;
            start_q      <= 1'b0;
            core_start   <= 1'b0;
            core_decrypt <= 1'b0;
            busy         <= 1'b0;
            ready        <= 1'b0;
            auth_ok      <= 1'b0;
            dout_sr      <= '0;
            tout_sr      <= '0;
        end else begin
            start_q    <= start;
            core_start <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_en) begin
                        state   <= S_LOAD;
                        ready   <= 1'b0;
                        auth_ok <= 1'b0;
                    end
                end
                S_LOAD: begin
                    // all_full reflects the fill before this cycle's beat.
                    if (start_edge && all_full) begin
                        state      <= S_START;
                        core_start <= 1'b1;
                    end
                end
                S_START: begin
                    core_decrypt <= decrypt;
                    busy         <= 1'b1;
                    state        <= S_BUSY;
                end
                S_BUSY: begin
                    if (core_done) begin
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        auth_ok <= core_decrypt ? tag_match : 1'b1;
                        dout_sr <= (PT_GATE && core_decrypt && !tag_match) ? '0 : core_dout;
                        tout_sr <= core_tag;
                        state   <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (load_en) begin
                        state   <= S_LOAD;
                        ready   <= 1'b0;
                        auth_ok <= 1'b0;
                    end else if (start_edge && all_full) begin
                        state      <= S_START;
                        ready      <= 1'b0;
                        core_start <= 1'b1;
                    end else if (unload_en) begin
                        dout_sr <= dout_sr << LANES;
                        tout_sr <= tout_sr << LANES;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
